// File: rtl/math_seq_pkg.sv
// Opcodes of the byte-serial math datapath, host command encodings and the
// sequencer state set. MUL states exist only when MATH_SEQ_MUL_EN is defined.
package math_seq_pkg;

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_SEL  = 8'h01;
  localparam logic [7:0] OP_CLR0 = 8'h02;
  localparam logic [7:0] OP_CLR1 = 8'h03;
  localparam logic [7:0] OP_LDB  = 8'h04;
  localparam logic [7:0] OP_ADD  = 8'h08;
  localparam logic [7:0] OP_XFR  = 8'h09;
  localparam logic [7:0] OP_SHL  = 8'h0A;
  localparam logic [7:0] OP_SHR  = 8'h0C;

  localparam logic [2:0] CMD_LOAD  = 3'd0;
  localparam logic [2:0] CMD_XFER  = 3'd1;
  localparam logic [2:0] CMD_ADD   = 3'd2;
  localparam logic [2:0] CMD_MUL   = 3'd3;
  localparam logic [2:0] CMD_READ  = 3'd4;
  localparam logic [2:0] CMD_CLEAR = 3'd5;

  typedef enum logic [4:0] {
    S_IDLE,
    S_LD_CLR, S_LD_WAIT, S_LD_SHL, S_LD_BYTE,
    S_RD_OUT, S_RD_SHR,
    S_XF_CLR, S_XF_CPY,
    S_ADD,
    S_CL_CLR0, S_CL_CLR1,
`ifdef MATH_SEQ_MUL_EN
    S_MU_CLR1, S_MU_CPY, S_MU_CLR0, S_MU_SHL, S_MU_ADD,
`endif
    S_NOP
  } state_e;

endpackage

// File: rtl/math_sequencer.sv
// Expands host macro-commands into primitive opcode/data sequences for the math
// datapath. Define MATH_SEQ_MUL_EN to build the MUL command; otherwise MUL is a NOP.
module math_sequencer
  import math_seq_pkg::*;
#(
  parameter int BITS = 128
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [7:0] cmd_arg,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [7:0] wr_data,
  output logic       rd_valid,
  input  logic       rd_ready,
  output logic [7:0] rd_data,
  output logic       busy,
  output logic       cmd_done,
  output logic [7:0] math_op,
  output logic [7:0] math_data,
  input  logic [7:0] math_q
);

  if (BITS < 8 || BITS % 8 != 0) begin : g_bits_check
    $error("math_sequencer: BITS must be a positive multiple of 8");
  end

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] byte_q, byte_d;
  logic [7:0] op_d, data_d;
  logic       wr_fire;
`ifdef MATH_SEQ_MUL_EN
  logic [7:0] k_q, k_d;
  logic [2:0] bit_q, bit_d;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      byte_q    <= '0;
      math_op   <= OP_NOP;
      math_data <= '0;
`ifdef MATH_SEQ_MUL_EN
      k_q       <= '0;
      bit_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      byte_q    <= byte_d;
      math_op   <= op_d;
      math_data <= data_d;
`ifdef MATH_SEQ_MUL_EN
      k_q       <= k_d;
      bit_q     <= bit_d;
`endif
    end
  end

  // A LOAD byte may be taken while the previous primitive is still issuing, so
  // an unstalled byte costs only its shift and load cycles.
  assign wr_ready = (state_q == S_LD_CLR  && cnt_q != 8'd0) ||
                    (state_q == S_LD_WAIT)                   ||
                    (state_q == S_LD_BYTE && cnt_q != 8'd1);
  assign wr_fire   = wr_ready & wr_valid;
  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign rd_valid  = (state_q == S_RD_OUT);
  assign rd_data   = math_q;

  // NOTE: every variable gets a default before the case, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    byte_d  = byte_q;
`ifdef MATH_SEQ_MUL_EN
    k_d     = k_q;
    bit_d   = bit_q;
`endif
    case (state_q)
      S_IDLE: if (cmd_valid) begin
        cnt_d = cmd_arg;
`ifdef MATH_SEQ_MUL_EN
        k_d   = cmd_arg;
        bit_d = 3'd7;
`endif
        case (cmd_op)
          CMD_LOAD:  state_d = S_LD_CLR;
          CMD_XFER:  state_d = S_XF_CLR;
          CMD_ADD:   state_d = S_ADD;
          CMD_READ:  state_d = (cmd_arg == 8'd0) ? S_NOP : S_RD_OUT;
          CMD_CLEAR: state_d = S_CL_CLR0;
`ifdef MATH_SEQ_MUL_EN
          CMD_MUL:   state_d = S_MU_CLR1;
`else
          CMD_MUL:   state_d = S_NOP;
`endif
          default:   state_d = S_NOP;
        endcase
      end
      S_LD_CLR, S_LD_WAIT, S_LD_BYTE: begin
        if (state_q == S_LD_CLR && cnt_q == 8'd0) begin
          state_d = S_IDLE;
        end else if (state_q == S_LD_BYTE && cnt_q == 8'd1) begin
          state_d = S_IDLE;
        end else begin
          if (state_q == S_LD_BYTE) cnt_d = cnt_q - 8'd1;
          if (wr_fire) begin
            byte_d  = wr_data;
            state_d = S_LD_SHL;
          end else begin
            state_d = S_LD_WAIT;
          end
        end
      end
      S_LD_SHL:  state_d = S_LD_BYTE;
      S_RD_OUT:  if (rd_ready) state_d = S_RD_SHR;
      S_RD_SHR: begin
        if (cnt_q == 8'd1) begin
          state_d = S_IDLE;
        end else begin
          cnt_d   = cnt_q - 8'd1;
          state_d = S_RD_OUT;
        end
      end
      S_XF_CLR:  state_d = S_XF_CPY;
      S_CL_CLR0: state_d = S_CL_CLR1;
`ifdef MATH_SEQ_MUL_EN
      S_MU_CLR1: state_d = S_MU_CPY;
      S_MU_CPY:  state_d = S_MU_CLR0;
      S_MU_CLR0: state_d = S_MU_SHL;
      S_MU_SHL: begin
        if (k_q[bit_q]) begin
          state_d = S_MU_ADD;
        end else if (bit_q == 3'd0) begin
          state_d = S_IDLE;
        end else begin
          bit_d = bit_q - 3'd1;
        end
      end
      S_MU_ADD: begin
        if (bit_q == 3'd0) begin
          state_d = S_IDLE;
        end else begin
          bit_d   = bit_q - 3'd1;
          state_d = S_MU_SHL;
        end
      end
`endif
      default:   state_d = S_IDLE;
    endcase
  end

  // Opcode is decoded from the next state and registered, so it lines up with
  // the cycle in which that state is current.
  always_comb begin
    op_d     = OP_NOP;
    data_d   = 8'h00;
    cmd_done = 1'b0;
    case (state_d)
      S_LD_CLR, S_CL_CLR0:     op_d = OP_CLR0;
      S_XF_CLR, S_CL_CLR1:     op_d = OP_CLR1;
      S_XF_CPY:                op_d = OP_XFR;
      S_ADD:                   op_d = OP_ADD;
      S_LD_SHL: begin          op_d = OP_SHL; data_d = 8'd8;   end
      S_LD_BYTE: begin         op_d = OP_LDB; data_d = byte_q; end
      S_RD_SHR: begin          op_d = OP_SHR; data_d = 8'd8;   end
`ifdef MATH_SEQ_MUL_EN
      S_MU_CLR1:               op_d = OP_CLR1;
      S_MU_CPY:                op_d = OP_XFR;
      S_MU_CLR0:               op_d = OP_CLR0;
      S_MU_ADD:                op_d = OP_ADD;
      S_MU_SHL: begin          op_d = OP_SHL; data_d = 8'd1;   end
`endif
      default: ;
    endcase
    case (state_q)
      S_LD_CLR:                          cmd_done = (cnt_q == 8'd0);
      S_LD_BYTE, S_RD_SHR:               cmd_done = (cnt_q == 8'd1);
      S_XF_CPY, S_ADD, S_CL_CLR1, S_NOP: cmd_done = 1'b1;
`ifdef MATH_SEQ_MUL_EN
      S_MU_SHL:                          cmd_done = (bit_q == 3'd0) && !k_q[0];
      S_MU_ADD:                          cmd_done = (bit_q == 3'd0);
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_math_sequencer.sv
// Scoreboard bench for math_sequencer: a behavioural datapath answers the opcode
// stream, and a value-level command model predicts read bytes and busy lengths.
`timescale 1ns/1ps
module tb_math_sequencer;
  import math_seq_pkg::*;

  localparam int BITS = 128;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready;
  logic [2:0] cmd_op;
  logic [7:0] cmd_arg;
  logic       wr_valid, wr_ready;
  logic [7:0] wr_data;
  logic       rd_valid, rd_ready;
  logic [7:0] rd_data;
  logic       busy, cmd_done;
  logic [7:0] math_op, math_data, math_q;

  always #5 clk = ~clk;

  math_sequencer #(.BITS(BITS)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_arg(cmd_arg),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .busy(busy), .cmd_done(cmd_done),
    .math_op(math_op), .math_data(math_data), .math_q(math_q)
  );

  // Datapath stand-in: acts on each presented opcode at the end of its cycle.
  logic [BITS-1:0] dp_acc0, dp_acc1;
  assign math_q = dp_acc0[7:0];
  always @(posedge clk) begin
    if (rst) begin
      dp_acc0 <= '0;
      dp_acc1 <= '0;
    end else begin
      case (math_op)
        8'h02: dp_acc0 <= '0;
        8'h03: dp_acc1 <= '0;
        8'h04: dp_acc0 <= dp_acc0 | BITS'(math_data);
        8'h08: dp_acc0 <= dp_acc0 + dp_acc1;
        8'h09: dp_acc1 <= dp_acc0;
        8'h0A: dp_acc0 <= dp_acc0 << math_data;
        8'h0C: dp_acc0 <= dp_acc0 >> math_data;
        default: ;
      endcase
    end
  end

  // Command-level reference state and scoreboard queues.
  logic [BITS-1:0] ref_a0, ref_a1;
  logic [7:0]      exp_rd[$];
  int              exp_len[$];
  logic [7:0]      ld_buf[$];
  int              checks = 0;
  int              errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: busy length excludes cycles where the host is the one stalling.
  int         cyc = 0;
  logic [7:0] mon_b;
  int         mon_len;
  always @(negedge clk) begin
    if (rst) begin
      cyc = 0;
    end else begin
      if (busy && !(wr_ready && !wr_valid) && !(rd_valid && !rd_ready)) cyc++;
      if (rd_valid && rd_ready) begin
        mon_b = (exp_rd.size() > 0) ? exp_rd.pop_front() : 8'hxx;
        check("rd_data", 32'(rd_data), 32'(mon_b));
      end
      if (cmd_done) begin
        mon_len = (exp_len.size() > 0) ? exp_len.pop_front() : -1;
        check("busy_cycles", 32'(cyc), 32'(mon_len));
        check("done_in_busy", 32'(busy), 32'd1);
        cyc = 0;
      end
      if (!busy) begin
        check("idle_math_op", 32'(math_op), 32'h0);
        check("idle_cmd_ready", 32'(cmd_ready), 32'd1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for IDLE; with poke set, offers a CLEAR while busy that must be ignored.
  task automatic wait_idle(input bit poke);
    int n;
    n = 0;
    while (!cmd_ready && n < 400) begin
      cmd_valid = poke && !cmd_done;
      cmd_op    = CMD_CLEAR;
      tick();
      n++;
    end
    cmd_valid = 1'b0;
    if (!cmd_ready) check("idle_timeout", 32'(cmd_ready), 32'd1);
  endtask

  task automatic send_cmd(input logic [2:0] op, input logic [7:0] arg);
    wait_idle(1'b0);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    tick();
    cmd_valid = 1'b0;
    cmd_op    = 3'($urandom);
    cmd_arg   = 8'($urandom);
  endtask

  task automatic wait_wr();
    int n;
    n = 0;
    while (!wr_ready && n < 400) begin tick(); n++; end
    if (!wr_ready) check("wr_ready_timeout", 32'(wr_ready), 32'd1);
    tick();
  endtask

  task automatic read_byte(input int stall);
    int n;
    rd_ready = 1'b0;
    repeat (stall) tick();
    rd_ready = 1'b1;
    n = 0;
    while (!rd_valid && n < 400) begin tick(); n++; end
    if (!rd_valid) check("rd_valid_timeout", 32'(rd_valid), 32'd1);
    tick();
    rd_ready = 1'b0;
  endtask

  task automatic do_load(input int n, input int stall_max);
    send_cmd(CMD_LOAD, 8'(n));
    exp_len.push_back(1 + 2 * n);
    ref_a0 = '0;
    for (int i = 0; i < n; i++) ref_a0 = (ref_a0 << 8) | BITS'(ld_buf[i]);
    rd_ready = 1'($urandom);
    for (int i = 0; i < n; i++) begin
      wr_valid = 1'b0;
      repeat ($urandom_range(stall_max, 0)) tick();
      wr_valid = 1'b1;
      wr_data  = ld_buf[i];
      wait_wr();
      wr_valid = 1'b0;
      wr_data  = 8'($urandom);
    end
    rd_ready = 1'b0;
  endtask

  task automatic push_read(input int n);
    logic [BITS-1:0] t;
    exp_len.push_back((n == 0) ? 1 : 2 * n);
    for (int i = 0; i < n; i++) begin
      t = ref_a0 >> (8 * i);
      exp_rd.push_back(t[7:0]);
    end
    ref_a0 = ref_a0 >> (8 * n);
  endtask

  task automatic do_read(input int n, input int stall_max);
    send_cmd(CMD_READ, 8'(n));
    push_read(n);
    wr_valid = 1'($urandom);
    for (int i = 0; i < n; i++) read_byte(int'($urandom_range(stall_max, 0)));
    wr_valid = 1'b0;
    wait_idle(1'b1);
  endtask

  task automatic do_simple(input logic [2:0] op, input logic [7:0] arg);
    send_cmd(op, arg);
    case (op)
      CMD_XFER:  begin ref_a1 = ref_a0; exp_len.push_back(2); end
      CMD_ADD:   begin ref_a0 = ref_a0 + ref_a1; exp_len.push_back(1); end
      CMD_CLEAR: begin ref_a0 = '0; ref_a1 = '0; exp_len.push_back(2); end
`ifdef MATH_SEQ_MUL_EN
      CMD_MUL: begin
        ref_a1 = ref_a0;
        ref_a0 = ref_a0 * BITS'(arg);
        exp_len.push_back(11 + $countones(arg));
      end
`endif
      default:   exp_len.push_back(1);
    endcase
    wr_valid = 1'($urandom);
    wr_data  = 8'($urandom);
    rd_ready = 1'($urandom);
    wait_idle(1'b1);
    wr_valid = 1'b0;
    rd_ready = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: run exceeded its time budget");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int sel;
    logic [7:0] b0;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_arg = '0;
    wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
    ref_a0 = '0; ref_a1 = '0;
    repeat (3) tick();
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_wr_ready",  32'(wr_ready),  32'd0);
    check("rst_rd_valid",  32'(rd_valid),  32'd0);
    check("rst_rd_data",   32'(rd_data),   32'h00);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_cmd_done",  32'(cmd_done),  32'd0);
    check("rst_math_op",   32'(math_op),   32'h00);
    check("rst_math_data", 32'(math_data), 32'h00);
    rst = 1'b0;
    tick();

    ld_buf = {8'h12, 8'h34}; do_load(2, 0);
    do_read(2, 0);

    ld_buf = {8'h80}; do_load(1, 0);
    do_simple(CMD_XFER, 8'h00);
    ld_buf = {8'h90}; do_load(1, 0);
    do_simple(CMD_ADD, 8'h00);
    do_read(2, 0);

    ld_buf = {8'h01, 8'h05}; do_load(2, 0);
    do_simple(CMD_MUL, 8'h03);
    do_read(2, 0);
    ld_buf = {8'hA7, 8'h3C}; do_load(2, 1);
    do_simple(CMD_MUL, 8'hFF);
    do_read(3, 1);
    ld_buf = {8'h55}; do_load(1, 0);
    do_simple(CMD_MUL, 8'h00);
    do_read(2, 0);

    // Reset in the middle of a LOAD, after its first byte.
    ld_buf = {8'hAB, 8'hCD};
    send_cmd(CMD_LOAD, 8'd2);
    wr_valid = 1'b1; wr_data = 8'hAB;
    wait_wr();
    wr_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("midrst_math_op",   32'(math_op),   32'h00);
    check("midrst_busy",      32'(busy),      32'd0);
    rst = 1'b0;
    exp_len.delete(); exp_rd.delete();
    ref_a0 = '0; ref_a1 = '0;
    do_read(1, 0);

    // READ with the host holding rd_ready low for five cycles on the first byte.
    ld_buf = {8'h5A, 8'hC3}; do_load(2, 0);
    send_cmd(CMD_READ, 8'd2);
    b0 = ref_a0[7:0];
    push_read(2);
    rd_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("stall_rd_valid", 32'(rd_valid), 32'd1);
      check("stall_rd_data",  32'(rd_data),  32'(b0));
      check("stall_math_op",  32'(math_op),  32'h00);
      tick();
    end
    read_byte(0);
    read_byte(0);
    wait_idle(1'b0);

    // Zero-length and oversize transfers, plus the reserved opcodes.
    ld_buf.delete(); do_load(0, 0);
    do_read(0, 0);
    do_simple(3'd6, 8'h00);
    do_simple(3'd7, 8'hFF);
    ld_buf.delete();
    for (int i = 0; i < 20; i++) ld_buf.push_back(8'(i * 13 + 1));
    do_load(20, 1);
    do_read(18, 1);

    for (int t = 0; t < 60; t++) begin
      sel = int'($urandom_range(7, 0));
      if (sel == 0 || sel == 4) begin
        n = ($urandom_range(7, 0) == 0) ? int'($urandom_range(19, 16)) : int'($urandom_range(4, 0));
        if (sel == 0) begin
          ld_buf.delete();
          for (int i = 0; i < n; i++) ld_buf.push_back(8'($urandom));
          do_load(n, 2);
        end else begin
          do_read(n, 2);
        end
      end else begin
        do_simple(3'(sel), 8'($urandom));
      end
    end

    wait_idle(1'b0);
    repeat (3) tick();
    check("rd_queue_drained",  32'(exp_rd.size()),  32'd0);
    check("len_queue_drained", 32'(exp_len.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
